// File: rtl/qspi_idreg.sv
// qspi_idreg: services JEDEC-ID and OTP read requests from the flash bus
// front end by driving the low-level QSPI word engine directly. The 20-byte
// JEDEC ID is read once and cached; later ID requests are served from the
// cache. Every request ends with a single-cycle acknowledge.
//
// Optional feature macro: QSPI_OTP_READ_EN
//   defined   : indices 0x10-0x1F perform an OTP read (0x4B command).
//   undefined : OTP states are not built; those indices ack with data 0.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_idreq, i_addr   level request and control-register index
//   o_ack, o_data     one-cycle acknowledge and its response word
//   o_idloaded        ID cache valid
//   o_busy            block owns the SPI driver port
//   o_spi_wr/hold/word/len/dir   word request to the QSPI driver
//   i_spi_busy/valid/data/stopped  driver status and read data
module qspi_idreg (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_idreq,
  input  logic [4:0]  i_addr,
  output logic        o_ack,
  output logic [31:0] o_data,
  output logic        o_idloaded,
  output logic        o_busy,
  output logic        o_spi_wr,
  output logic        o_spi_hold,
  output logic [31:0] o_spi_word,
  output logic [1:0]  o_spi_len,
  output logic        o_spi_dir,
  input  logic        i_spi_busy,
  input  logic        i_spi_valid,
  input  logic [31:0] i_spi_data,
  input  logic        i_spi_stopped
);

  localparam int unsigned IdWords = 5;
  localparam int unsigned CntW    = 3;
  localparam int unsigned IdxW    = 5;
  localparam int unsigned WordW   = 32;
  localparam logic [WordW-1:0] RdidWord = 32'h9F00_0000;
  localparam logic [7:0]       OtpCmd   = 8'h4B;
  localparam logic [1:0]       LenByte  = 2'd0;
  localparam logic [1:0]       LenWord  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_RDID   = 4'd2,
`ifdef QSPI_OTP_READ_EN
    ST_OTPADR = 4'd3,
    ST_OTPDMY = 4'd4,
    ST_OTPRD  = 4'd5,
`endif
    ST_STOP   = 4'd6,
    ST_ACK    = 4'd7,
    ST_DROP   = 4'd8
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CntW-1:0]        issue_q, issue_d;
  logic                   from_id_q, from_id_d;
  logic [WordW-1:0]       id_q [IdWords];
  logic [WordW-1:0]       id_d [IdWords];
  logic                   ack_q, ack_d;
  logic [WordW-1:0]       data_q, data_d;
  logic                   idloaded_q, idloaded_d;
  logic                   busy_q, busy_d;
  logic                   wr_q, wr_d;
  logic                   hold_q, hold_d;
  logic [WordW-1:0]       word_q, word_d;
  logic [1:0]             len_q, len_d;
  logic                   dir_q, dir_d;

  // Request decode on the live index (used only in IDLE) and on the latched one.
  logic                   addr_is_id;
  logic [CntW-1:0]        addr_sel;
  logic [CntW-1:0]        idx_sel;
  logic                   spi_acc;

  assign addr_is_id = (i_addr >= 5'h08) && (i_addr <= 5'h0C);
  assign addr_sel   = CntW'(i_addr - 5'd8);
  assign idx_sel    = CntW'(idx_q - 5'd8);
  assign spi_acc    = wr_q && !i_spi_busy;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    issue_d    = issue_q;
    from_id_d  = from_id_q;
    id_d       = id_q;
    ack_d      = 1'b0;
    data_d     = data_q;
    idloaded_d = idloaded_q;
    wr_d       = wr_q;
    hold_d     = hold_q;
    word_d     = word_q;
    len_d      = len_q;
    dir_d      = dir_q;

    case (state_q)
      ST_IDLE: begin
        if (i_idreq && i_spi_stopped) begin
          idx_d = i_addr;
          if (addr_is_id) begin
            if (idloaded_q) begin
              state_d = ST_ACK;
              data_d  = id_q[addr_sel];
            end else begin
              state_d   = ST_CMD;
              from_id_d = 1'b1;
              cnt_d     = '0;
              issue_d   = '0;
              wr_d      = 1'b1;
              word_d    = RdidWord;
              len_d     = LenByte;
              dir_d     = 1'b0;
              hold_d    = 1'b1;
            end
          end
`ifdef QSPI_OTP_READ_EN
          else if (i_addr[4]) begin
            state_d   = ST_OTPADR;
            from_id_d = 1'b0;
            wr_d      = 1'b1;
            word_d    = {OtpCmd, 16'h0000, 2'b00, i_addr[3:0], 2'b00};
            len_d     = LenWord;
            dir_d     = 1'b0;
            hold_d    = 1'b1;
          end
`endif
          else begin
            // OTP program, unmapped indices (and OTP reads when not built).
            state_d = ST_ACK;
            data_d  = '0;
          end
        end
      end

      ST_CMD: begin
        // Command accepted: queue the first ID read straight away.
        if (spi_acc) begin
          state_d = ST_RDID;
          wr_d    = 1'b1;
          word_d  = '0;
          len_d   = LenWord;
          dir_d   = 1'b1;
          hold_d  = 1'b1;
        end
      end

      ST_RDID: begin
        // Issue side: queue the next read; only the last one releases CS.
        if (spi_acc) begin
          issue_d = CntW'(issue_q + 3'd1);
          if (issue_q < CntW'(IdWords - 1)) begin
            wr_d   = 1'b1;
            hold_d = (issue_q < CntW'(IdWords - 2));
          end else begin
            wr_d = 1'b0;
          end
        end
        // Return side: runs independently so a valid may coincide with an issue.
        if (i_spi_valid) begin
          id_d[cnt_q] = i_spi_data;
          cnt_d       = CntW'(cnt_q + 3'd1);
          if (cnt_q == CntW'(IdWords - 1)) begin
            state_d = ST_STOP;
          end
        end
      end

`ifdef QSPI_OTP_READ_EN
      ST_OTPADR: begin
        if (spi_acc) begin
          state_d = ST_OTPDMY;
          wr_d    = 1'b1;
          word_d  = '0;
          len_d   = LenByte;
          dir_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end

      ST_OTPDMY: begin
        if (spi_acc) begin
          state_d = ST_OTPRD;
          wr_d    = 1'b1;
          word_d  = '0;
          len_d   = LenWord;
          dir_d   = 1'b1;
          hold_d  = 1'b0;
        end
      end

      ST_OTPRD: begin
        if (spi_acc) begin
          wr_d = 1'b0;
        end
        if (i_spi_valid) begin
          data_d  = i_spi_data;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        // Wait for the driver to raise CS before acknowledging.
        if (i_spi_stopped) begin
          state_d = ST_ACK;
          if (from_id_q) begin
            idloaded_d = 1'b1;
            data_d     = id_q[idx_sel];
          end
        end
      end

      ST_ACK: begin
        ack_d   = 1'b1;
        state_d = ST_DROP;
      end

      ST_DROP: begin
        // Swallow the still-held request so it cannot retrigger.
        if (!i_idreq) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        wr_d    = 1'b0;
        hold_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_ACK) && (state_d != ST_DROP);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      issue_q    <= '0;
      from_id_q  <= 1'b0;
      id_q       <= '{default: '0};
      ack_q      <= 1'b0;
      data_q     <= '0;
      idloaded_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      hold_q     <= 1'b0;
      word_q     <= '0;
      len_q      <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      issue_q    <= issue_d;
      from_id_q  <= from_id_d;
      id_q       <= id_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      idloaded_q <= idloaded_d;
      busy_q     <= busy_d;
      wr_q       <= wr_d;
      hold_q     <= hold_d;
      word_q     <= word_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_data     = data_q;
  assign o_idloaded = idloaded_q;
  assign o_busy     = busy_q;
  assign o_spi_wr   = wr_q;
  assign o_spi_hold = hold_q;
  assign o_spi_word = word_q;
  assign o_spi_len  = len_q;
  assign o_spi_dir  = dir_q;

endmodule

// File: tb/tb_qspi_idreg.sv
// Testbench for qspi_idreg: behavioural QSPI driver model plus scoreboards for
// the SPI word stream and for the acknowledged response words.
module tb_qspi_idreg;

  logic        clk = 1'b0;
  logic        rst;
  logic        idreq;
  logic [4:0]  addr;
  logic        o_ack;
  logic [31:0] o_data;
  logic        o_idloaded;
  logic        o_busy;
  logic        spi_wr;
  logic        spi_hold;
  logic [31:0] spi_word;
  logic [1:0]  spi_len;
  logic        spi_dir;
  logic        spi_busy;
  logic        spi_valid;
  logic [31:0] spi_data;
  logic        spi_stopped;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int rst_cyc    = 0;
  int words_seen = 0;
  int wr_cycles  = 0;
  int ack_count  = 0;
  int stop_cyc   = 0;

  logic [35:0] exp_spi[$];   // {word, len, dir, hold}
  logic [32:0] exp_resp[$];  // {idloaded, data}
  logic [31:0] rd_data[$];   // words the driver model returns

  always #5 clk = ~clk;

  qspi_idreg dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_idreq      (idreq),
    .i_addr       (addr),
    .o_ack        (o_ack),
    .o_data       (o_data),
    .o_idloaded   (o_idloaded),
    .o_busy       (o_busy),
    .o_spi_wr     (spi_wr),
    .o_spi_hold   (spi_hold),
    .o_spi_word   (spi_word),
    .o_spi_len    (spi_len),
    .o_spi_dir    (spi_dir),
    .i_spi_busy   (spi_busy),
    .i_spi_valid  (spi_valid),
    .i_spi_data   (spi_data),
    .i_spi_stopped(spi_stopped)
  );

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle and reset counters, sampled on the active edge.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst) rst_cyc = rst_cyc + 1;
  end

  // Driver model: accept, stay busy 3 cycles, return read data, release CS
  // after a non-hold word or after a reset aborted the transfer.
  initial begin
    logic        cur_dir, cur_hold;
    logic [35:0] e;
    int          rst_mark;
    spi_busy    = 1'b0;
    spi_valid   = 1'b0;
    spi_data    = '0;
    spi_stopped = 1'b1;
    forever begin
      @(negedge clk);
      while (spi_wr && !spi_busy && !rst) begin
        words_seen++;
        if (exp_spi.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spi_unexpected: word 0x%08h len %0d dir %0d hold %0d",
                   spi_word, spi_len, spi_dir, spi_hold);
        end else begin
          e = exp_spi.pop_front();
          chk("spi_word", {spi_word, spi_len, spi_dir, spi_hold}, e);
        end
        cur_dir  = spi_dir;
        cur_hold = spi_hold;
        rst_mark = rst_cyc;
        @(negedge clk);
        spi_busy    = 1'b1;
        spi_stopped = 1'b0;
        repeat (2) @(negedge clk);
        if (cur_dir) begin
          spi_valid = 1'b1;
          spi_data  = (rd_data.size() != 0) ? rd_data.pop_front() : 32'h0;
          @(negedge clk);
          spi_valid = 1'b0;
        end
        spi_busy = 1'b0;
        if (!cur_hold || (rst_cyc != rst_mark)) begin
          repeat (2) @(negedge clk);
          spi_stopped = 1'b1;
          stop_cyc    = cyc;
        end
      end
    end
  end

  // Response monitor: every ack pops one expected {idloaded, data}.
  initial begin
    logic [32:0] r;
    forever begin
      @(negedge clk);
      if (spi_wr) wr_cycles++;
      if (o_ack) begin
        ack_count++;
        if (exp_resp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ack_unexpected: data 0x%08h", o_data);
        end else begin
          r = exp_resp.pop_front();
          chk("ack_data", 36'(o_data), 36'(r[31:0]));
          chk("ack_idloaded", 36'(o_idloaded), 36'(r[32]));
        end
      end
    end
  end

  task automatic push_id_read();
    exp_spi.push_back({32'h9F00_0000, 2'd0, 1'b0, 1'b1});
    for (int i = 0; i < 5; i++) exp_spi.push_back({32'h0, 2'd3, 1'b1, (i < 4) ? 1'b1 : 1'b0});
    rd_data.push_back(32'hC220_1800);
    rd_data.push_back(32'h0000_0011);
    rd_data.push_back(32'h0000_0022);
    rd_data.push_back(32'h0000_0033);
    rd_data.push_back(32'h0000_0044);
  endtask

  // mode 0: ack 2 cycles after request, no SPI traffic;
  // mode 1: ack 2 cycles after the driver's final CS release.
  task automatic do_req(input logic [4:0] a, input logic [31:0] exp_data, input logic exp_loaded,
                        input int mode, input int hold_extra);
    int wr0, acks0, lat;
    bit got;
    wr0   = wr_cycles;
    acks0 = ack_count;
    lat   = 0;
    exp_resp.push_back({exp_loaded, exp_data});
    @(negedge clk);
    idreq = 1'b1;
    addr  = a;
    got   = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (o_ack) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: addr 0x%0h got no ack required one within 400 cycles", a);
    end else if (mode == 0) begin
      chk("ack_latency", 36'(lat), 36'd2);
    end else begin
      chk("ack_after_stop", 36'(cyc - stop_cyc), 36'd2);
    end
    for (int i = 0; i < hold_extra; i++) begin
      @(negedge clk);
      chk("data_stable", 36'(o_data), 36'(exp_data));
      chk("busy_in_drop", 36'(o_busy), 36'd0);
    end
    @(negedge clk);
    idreq = 1'b0;
    repeat (4) @(negedge clk);
    chk("one_ack", 36'(ack_count - acks0), 36'd1);
    if (mode == 0) chk("no_spi_wr", 36'(wr_cycles - wr0), 36'd0);
    chk("spi_queue_drained", 36'(exp_spi.size()), 36'd0);
    chk("resp_queue_drained", 36'(exp_resp.size()), 36'd0);
  endtask

  initial begin
    int  base, acks0;
    bit  got;
    rst   = 1'b1;
    idreq = 1'b0;
    addr  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 36'(o_ack), 36'd0);
    chk("rst_data", 36'(o_data), 36'd0);
    chk("rst_idloaded", 36'(o_idloaded), 36'd0);
    chk("rst_busy", 36'(o_busy), 36'd0);
    chk("rst_spi_wr", 36'(spi_wr), 36'd0);
    chk("rst_spi_hold", 36'(spi_hold), 36'd0);
    chk("rst_spi_word", 36'(spi_word), 36'd0);
    chk("rst_spi_len", 36'(spi_len), 36'd0);
    chk("rst_spi_dir", 36'(spi_dir), 36'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Uncached ID read, then cache hits including both range ends.
    push_id_read();
    do_req(5'h08, 32'hC220_1800, 1'b1, 1, 0);
    do_req(5'h0B, 32'h0000_0033, 1'b1, 0, 0);
    do_req(5'h0F, 32'h0, 1'b1, 0, 0);
    do_req(5'h0C, 32'h0000_0044, 1'b1, 0, 0);
    do_req(5'h03, 32'h0, 1'b1, 0, 0);
    do_req(5'h07, 32'h0, 1'b1, 0, 0);

`ifdef QSPI_OTP_READ_EN
    exp_spi.push_back({32'h4B00_000C, 2'd3, 1'b0, 1'b1});
    exp_spi.push_back({32'h0, 2'd0, 1'b0, 1'b1});
    exp_spi.push_back({32'h0, 2'd3, 1'b1, 1'b0});
    rd_data.push_back(32'hDEAD_BEEF);
    do_req(5'h13, 32'hDEAD_BEEF, 1'b1, 1, 0);
`else
    do_req(5'h13, 32'h0, 1'b1, 0, 0);
    do_req(5'h1F, 32'h0, 1'b1, 0, 0);
`endif

    // Request held high well past the ack.
    do_req(5'h0A, 32'h0000_0022, 1'b1, 0, 10);

    // Reset during the third ID read of a fresh load.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("cache_cleared", 36'(o_idloaded), 36'd0);
    acks0 = ack_count;
    base  = words_seen;
    exp_spi.push_back({32'h9F00_0000, 2'd0, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) exp_spi.push_back({32'h0, 2'd3, 1'b1, 1'b1});
    rd_data.push_back(32'hA1);
    rd_data.push_back(32'hA2);
    rd_data.push_back(32'hA3);
    @(negedge clk);
    idreq = 1'b1;
    addr  = 5'h08;
    got   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (words_seen >= base + 4) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL third_read_timeout: words %0d required %0d", words_seen - base, 4);
    end
    chk("busy_mid_read", 36'(o_busy), 36'd1);
    @(negedge clk);
    rst   = 1'b1;
    idreq = 1'b0;
    @(negedge clk);
    chk("midrst_spi_wr", 36'(spi_wr), 36'd0);
    chk("midrst_spi_hold", 36'(spi_hold), 36'd0);
    chk("midrst_idloaded", 36'(o_idloaded), 36'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_ack", 36'(ack_count - acks0), 36'd0);
    chk("midrst_spi_queue", 36'(exp_spi.size()), 36'd0);

    // Restart must begin again with the 0x9F command.
    push_id_read();
    do_req(5'h08, 32'hC220_1800, 1'b1, 1, 0);
    do_req(5'h09, 32'h0000_0011, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_idreg.md
# qspi_idreg

Services the QSPI flash identification and OTP read requests raised by the flash bus front end (`o_idreq` with its latched address). It drives the low-level QSPI word engine directly and caches the 20-byte JEDEC ID after the first read. It returns each requested word with a single-cycle acknowledge and reports `o_idloaded` back to the front end's status word. It sits between the bus front end and the low-level QSPI driver; the parent muxes the driver port to this block whenever `o_busy` is high.

## Interface

No parameters.

- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_idreq` in 1: level request from the front end; held until one cycle after `o_ack`.
- `i_addr` in 5: control-register index; `0x08`–`0x0C` are ID words, `0x0F` is OTP program, `0x10`–`0x1F` are OTP read.
- `o_ack` out 1: one-cycle acknowledge.
- `o_data` out 32: response word, valid with `o_ack`.
- `o_idloaded` out 1: ID cache valid.
- `o_busy` out 1: block owns the SPI port.
- `o_spi_wr` out 1: word request to the driver.
- `o_spi_hold` out 1: keep CS low after this word.
- `o_spi_word` out 32: transmit word, MSB first.
- `o_spi_len` out 2: byte count minus one.
- `o_spi_dir` out 1: 0 = write, 1 = read.
- `i_spi_busy` in 1: driver cannot accept a word.
- `i_spi_valid` in 1: one-cycle strobe; read word complete.
- `i_spi_data` in 32: read word.
- `i_spi_stopped` in 1: CS high and driver idle.

## Operation

- **States:** IDLE, CMD, RDID, OTPADR, OTPDMY, OTPRD, STOP, ACK, DROP.
- **Word handshake:** a word is accepted in the cycle `o_spi_wr && !i_spi_busy`. After acceptance, `o_spi_wr` drops the next cycle unless another word follows.
- **IDLE:**
  - Leaves IDLE when `i_idreq` is high and `i_spi_stopped` is high; `i_addr` is latched at that point.
  - Index `0x08`–`0x0C` with `o_idloaded`=1: go to ACK, `o_data` = `id[idx-8]`.
  - Index `0x08`–`0x0C` with `o_idloaded`=0: go to CMD.
  - Index `0x0F`: go to ACK with `o_data`=0. Writes are never performed.
  - Index `0x10`–`0x1F`: go to OTPADR.
  - All other indices: go to ACK with `o_data`=0.
- **CMD:** sends word `0x9F000000` with len=0, dir=0, hold=1, then goes to RDID.
- **RDID:**
  - Issues 5 reads, each len=3, dir=1; hold=1 on the first four and 0 on the fifth.
  - A 3-bit counter indexes the read; each `i_spi_valid` stores `id[cnt]`.
  - After the fifth valid, go to STOP.
- **OTPADR:** sends `{8'h4B, 16'h0000, 2'b00, idx[3:0], 2'b00}` with len=3, hold=1.
- **OTPDMY:** sends one dummy byte (0, len=0, hold=1).
- **OTPRD:** issues one read with len=3, dir=1, hold=0; `i_spi_valid` latches `o_data`.
- **STOP:** waits for `i_spi_stopped`. If coming from an ID read, sets `o_idloaded`=1 and loads `o_data` = `id[idx-8]`.
- **ACK:** `o_ack`=1 for one cycle, then go to DROP.
- **DROP:** waits for `i_idreq`=0, then go to IDLE. This prevents the held request from retriggering.
- **`o_busy`:** 1 in every state except IDLE, ACK and DROP.
- **Reset:**
  - Every output resets to 0: `o_ack`, `o_data`, `o_idloaded`, `o_busy`, `o_spi_wr`, `o_spi_hold`, `o_spi_word`, `o_spi_len`, `o_spi_dir`.
  - The ID cache is invalidated.
  - Reset mid-transfer drops `o_spi_wr` and `o_spi_hold` the next cycle; the driver completes its own word and releases CS.

## Timing

- **Cached ID hit:** `o_ack` 2 cycles after `i_idreq` is sampled high (IDLE → ACK → ack registered).
- **Uncached ID read:** ack 2 cycles after the final `i_spi_stopped` rise.
- **OTP program and unmapped indices:** 2 cycles.
- **`o_data`:** stable from `o_ack` until the next request is accepted.
- **`i_spi_valid`:** accepted in any cycle of RDID or OTPRD, including the same cycle the next word is issued.
- **`i_idreq` dropping before ACK:** the transaction still completes and acks. The front end ignores a stray ack.

## Configuration

- `QSPI_OTP_READ_EN` defined: OTP reads on indices `0x10`–`0x1F` run as described (states OTPADR, OTPDMY, OTPRD).
- Not defined: those states are not built, and indices `0x10`–`0x1F` ack in 2 cycles with `o_data`=0 and no SPI traffic.

## Test plan

- Reset, then `i_idreq` with index `0x08`:
  - SPI sequence is `0x9F`, then 5 read words.
  - Driver model returns `0xC2201800`, `0x11`, `0x22`, `0x33`, `0x44`.
  - Response: `o_ack` with `o_data`=`0xC2201800` and `o_idloaded`=1.
- Follow-up request with index `0x0B`: ack in 2 cycles with `0x33` and no `o_spi_wr` pulses.
- Index `0x0F`: ack in 2 cycles with `o_data`=0; `o_spi_wr` is never asserted.
- With `QSPI_OTP_READ_EN`, index `0x13`:
  - Words sent: `0x4B00000C` (len=3), `0x00` (len=0), then a read.
  - Returned `0xDEADBEEF` appears on `o_data` with the ack.
- Assert `i_rst` during the third RDID read:
  - `o_spi_wr`=0 and `o_idloaded`=0 next cycle.
  - The next index-`0x08` request restarts from `0x9F`.
- Hold `i_idreq` high for 10 cycles after the ack: exactly one `o_ack` pulse, and the block stays in DROP until `i_idreq` falls.
